// File: rtl/rf_scoreboard_pkg.sv
// Shared register-file scoreboard constants, counter op encoding and op decode helper.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Build option RF_SB_BYPASS_EN is consumed by rf_scoreboard, not here.
package rf_scoreboard_pkg;

    localparam int RF_ADDR_WD = 5;
    localparam int RF_NUM     = 32;
    localparam int SB_CNT_WD  = 2;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2,
        CNT_CLR  = 2'd3
    } cnt_op_e;

    // Clear dominates; a simultaneous increment and decrement cancel out.
    function automatic cnt_op_e sb_op(input logic clr, input logic inc, input logic dec);
        cnt_op_e op;
        if (clr)
            op = CNT_CLR;
        else if (inc && !dec)
            op = CNT_INC;
        else if (dec && !inc)
            op = CNT_DEC;
        else
            op = CNT_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/rf_scoreboard_sb_counter.sv
// One saturating up/down in-flight write counter for a single architectural register.
// Latency: count updates at the next clock edge; nz/full/err are combinational views.
// Backpressure: none; full is fed back so the issuer can hold off further increments.
module sb_counter
    import rf_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_WD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             nz,
    output logic             full,
    output logic             err
);

    localparam logic [CNT_W-1:0] MAX_CNT = {CNT_W{1'b1}};

    cnt_op_e op;

    assign op   = sb_op(clr, inc, dec);
    assign nz   = |cnt;
    assign full = (cnt == MAX_CNT);
    // Overflowing a full counter or underflowing an empty one is a bound violation.
    assign err  = ((op == CNT_INC) && full) || ((op == CNT_DEC) && !nz);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case (op)
                CNT_CLR: cnt <= '0;
                CNT_INC: if (!full) cnt <= cnt + 1'b1;
                CNT_DEC: if (nz)    cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/rf_scoreboard.sv
// Register-file scoreboard: per-register in-flight write counters, combinational ID stall.
// Latency: stall is same-cycle from ID fields; counters and busy_vec update one edge after the event.
// Backpressure: id_stall holds ID on RAW hazards or a full counter. Option RF_SB_BYPASS_EN releases on the commit cycle.
module rf_scoreboard
    import rf_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_WD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_issue,
    input  logic                  id_w_en,
    input  logic [RF_ADDR_WD-1:0] id_w_addr,
    input  logic [RF_ADDR_WD-1:0] id_rs,
    input  logic [RF_ADDR_WD-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic                  wb_commit,
    input  logic [RF_ADDR_WD-1:0] wb_w_addr,
    input  logic                  flush,
    output logic                  id_stall,
    output logic [RF_NUM-1:0]     busy_vec,
    output logic                  err_ovf
);

    logic [RF_NUM-1:1] inc_vec;
    logic [RF_NUM-1:1] dec_vec;
    logic [RF_NUM-1:1] err_vec;
    logic [RF_NUM-1:0] nz_vec;
    logic [RF_NUM-1:0] full_vec;
    logic [RF_NUM-1:0] busy_rd;

    // $0 has no counter, so its entries are tied off and it never stalls.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 1; i < RF_NUM; i++) begin
            inc_vec[i] = id_issue && id_w_en && (id_w_addr == RF_ADDR_WD'(i));
            dec_vec[i] = wb_commit && (wb_w_addr == RF_ADDR_WD'(i));
        end
    end

    assign nz_vec[0]   = 1'b0;
    assign full_vec[0] = 1'b0;
    assign busy_vec[0] = 1'b0;

`ifdef RF_SB_BYPASS_EN
    logic [RF_NUM-1:0] byp_vec;
    assign byp_vec[0] = 1'b0;
`endif

    for (genvar i = 1; i < RF_NUM; i++) begin : g_reg
        logic [CNT_W-1:0] cnt;

        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk  (clk),
            .rst  (reset),
            .inc  (inc_vec[i]),
            .dec  (dec_vec[i]),
            .clr  (flush),
            .cnt  (cnt),
            .nz   (nz_vec[i]),
            .full (full_vec[i]),
            .err  (err_vec[i])
        );

        assign busy_vec[i] = |cnt;
`ifdef RF_SB_BYPASS_EN
        // The last outstanding write lands this cycle and the RF writes through to the read port.
        assign byp_vec[i] = dec_vec[i] && (cnt == CNT_W'(1));
`endif
    end

`ifdef RF_SB_BYPASS_EN
    assign busy_rd = nz_vec & ~byp_vec;
`else
    assign busy_rd = nz_vec;
`endif

    assign id_stall = (id_rs_used && busy_rd[id_rs])
                    | (id_rt_used && busy_rd[id_rt])
                    | (id_w_en && full_vec[id_w_addr]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_ovf <= 1'b0;
        else if (|err_vec)
            err_ovf <= 1'b1;
    end

endmodule
